// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch/control slice of the core.
// Imported by fetch_unit and next_pc_logic.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_ALU    = 2'b10
  } pcsrc_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for the fetch stage.
// Also reports whether the chosen target is off a word boundary.
module next_pc_logic #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] PC,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] next,
  output logic            misaligned
);

  import riscv_pkg::*;

  logic [XLEN-1:0] alu_even;

  // JALR always drops bit 0 of the computed target; the reserved encoding falls back to PC+4
  assign alu_even = ALUResult & ~XLEN'(1);

  always_comb begin
    next = PC + XLEN'(4);
    case (PCSrc)
      PC_TARGET: next = PC + ImmExt;
      PC_ALU:    next = alu_even;
      default:   next = PC + XLEN'(4);
    endcase
  end

  assign misaligned = |next[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from instruction memory
// and hands each fetched instruction to control_unit until it retires.
module fetch_unit #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] Instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [XLEN-1:0] ALUResult,
  output logic            fetch_misaligned,
  output logic [31:0]     instret
);

  import riscv_pkg::*;

  fetch_state_e    state;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;
  logic            retire;

  assign retire    = instr_valid & instr_ready;
  assign imem_addr = PC;
  assign PCPlus4   = PC + XLEN'(4);

  next_pc_logic #(.XLEN(XLEN)) u_next_pc (
    .PC         (PC),
    .PCSrc      (PCSrc),
    .ImmExt     (ImmExt),
    .ALUResult  (ALUResult),
    .next       (next_pc),
    .misaligned (next_misaligned)
  );

  // A misaligned target still retires the current instruction, then parks in HALT
  // with PC left pointing at the offending instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      PC               <= RESET_PC;
      Instr            <= XLEN'(NOP_INSTR);
      instr_valid      <= 1'b0;
      imem_req_valid   <= 1'b0;
      fetch_misaligned <= 1'b0;
      instret          <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          state          <= REQ;
          imem_req_valid <= 1'b1;
        end
        REQ: begin
          if (imem_req_ready) begin
            state          <= WAIT;
            imem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            Instr       <= imem_rsp_data;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (retire) begin
            instret     <= instret + 32'd1;
            instr_valid <= 1'b0;
            if (!next_misaligned) begin
              PC             <= next_pc;
              state          <= REQ;
              imem_req_valid <= 1'b1;
            end else begin
              fetch_misaligned <= 1'b1;
              state            <= HALT;
            end
          end
        end
        HALT: begin
        end
        default: begin
          state          <= IDLE;
          imem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural instruction memory, directed
// corner-case sequences, a table of chained retires and a randomized run.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic [31:0] Instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] ImmExt = 32'd0;
  logic [31:0] ALUResult = 32'd0;
  logic        fetch_misaligned;
  logic [31:0] instret;

  int tests_run = 0;
  int tests_failed = 0;

  // memory model knobs
  bit          rand_ready = 0;
  bit          rand_lat = 0;
  bit          spur_rand = 0;
  bit          force_spurious = 0;
  int          lat_fixed = 0;
  int          stall_cnt = 0;
  bit          pend = 0;
  int          rsp_wait = 0;
  logic [31:0] paddr = 32'd0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_addr        (imem_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .Instr            (Instr),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .PC               (PC),
    .PCPlus4          (PCPlus4),
    .PCSrc            (PCSrc),
    .ImmExt           (ImmExt),
    .ALUResult        (ALUResult),
    .fetch_misaligned (fetch_misaligned),
    .instret          (instret)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr == 32'd0) return 32'h0320_0093;
    return {addr[15:0], ~addr[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory drives its inputs on the falling edge so they are stable at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      pend = 0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (pend) begin
        if (rsp_wait == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = memWord(paddr);
          pend = 0;
        end else begin
          rsp_wait--;
        end
      end else if (!imem_req_valid && (force_spurious || (spur_rand && $urandom_range(0, 3) == 0))) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
      if (stall_cnt > 0) begin
        imem_req_ready = 1'b0;
        stall_cnt--;
      end else begin
        imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend = 1;
        paddr = imem_addr;
        rsp_wait = rand_lat ? int'($urandom_range(0, 3)) : lat_fixed;
      end
    end
  end

  // A pending request must keep valid and address stable until it is accepted.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  bit          mon_armed = 0;
  always @(posedge clk) begin
    #1;
    if (rst_n && mon_armed && prev_valid && !imem_req_ready) begin
      checkOutput("req_hold_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("req_hold_addr", imem_addr, prev_addr);
    end
    mon_armed  = rst_n;
    prev_valid = imem_req_valid;
    prev_addr  = imem_addr;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic doReset();
    rst_n = 1'b0;
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic waitValid();
    for (int i = 0; i < 64 && !instr_valid; i++) tick();
    if (!instr_valid) checkOutput("wait_instr_valid", 32'(instr_valid), 32'd1);
  endtask

  task automatic applyStimulus(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu,
                               input int hold, input logic [31:0] exp_cur_pc);
    waitValid();
    checkOutput("pc_before_retire", PC, exp_cur_pc);
    checkOutput("instr_before_retire", Instr, memWord(exp_cur_pc));
    checkOutput("pcplus4", PCPlus4, exp_cur_pc + 32'd4);
    repeat (hold) tick();
    PCSrc = src;
    ImmExt = imm;
    ALUResult = alu;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    PCSrc = 2'($urandom);
    ImmExt = $urandom;
    ALUResult = $urandom;
  endtask

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] nxt;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [1:0]  src;
    bit          saw_req;
    int          k;

    vecs[0] = '{2'b00, 32'h0000_0040, 32'h0000_0077, 32'h0000_0004, 1'b0};
    vecs[1] = '{2'b01, 32'h0000_0100, 32'h0000_0000, 32'h0000_0104, 1'b0};
    vecs[2] = '{2'b10, 32'h0000_0000, 32'h0000_0205, 32'h0000_0204, 1'b0};
    vecs[3] = '{2'b01, 32'hFFFF_FFF8, 32'h0000_0011, 32'h0000_01FC, 1'b0};
    vecs[4] = '{2'b11, 32'h0000_1000, 32'h0000_0003, 32'h0000_0200, 1'b0};
    vecs[5] = '{2'b10, 32'h0000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0};
    vecs[6] = '{2'b00, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[7] = '{2'b01, 32'h0000_000C, 32'h0000_0000, 32'h0000_000C, 1'b0};
    vecs[8] = '{2'b01, 32'h0000_0002, 32'h0000_0000, 32'h0000_000C, 1'b1};

    // Reset state and first fetch with zero-wait memory
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_pc", PC, 32'd0);
    checkOutput("rst_instr", Instr, 32'h0000_0013);
    checkOutput("rst_instret", instret, 32'd0);
    checkOutput("rst_misaligned", 32'(fetch_misaligned), 32'd0);
    doReset();
    tick();
    checkOutput("t1_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("t1_addr", imem_addr, 32'd0);
    tick();
    checkOutput("t1_wait_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("t1_wait_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    checkOutput("t1_instr_valid", 32'(instr_valid), 32'd1);
    checkOutput("t1_instr", Instr, 32'h0320_0093);
    checkOutput("t1_pc", PC, 32'd0);
    checkOutput("t1_pcplus4", PCPlus4, 32'd4);

    // Sequential retire while memory holds off acceptance
    PCSrc = 2'b00;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    stall_cnt = 3;
    checkOutput("t2_instret", instret, 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_stall_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("t2_stall_addr", imem_addr, 32'd4);
      if (i < 3) tick();
    end
    tick();
    checkOutput("t2_accepted", 32'(imem_req_valid), 32'd0);

    // Backward branch from 0x8 to 0x0
    applyStimulus(2'b00, 32'd0, 32'd0, 1, 32'd4);
    applyStimulus(2'b01, 32'hFFFF_FFF8, 32'd0, 0, 32'd8);
    checkOutput("t3_pc", PC, 32'd0);
    checkOutput("t3_addr", imem_addr, 32'd0);
    checkOutput("t3_req_valid", 32'(imem_req_valid), 32'd1);

    // JALR clears bit 0; a target with bit 1 set halts fetch
    applyStimulus(2'b10, 32'd0, 32'h0000_0105, 0, 32'd0);
    checkOutput("t4_pc", PC, 32'h0000_0104);
    applyStimulus(2'b10, 32'd0, 32'h0000_0106, 2, 32'h0000_0104);
    checkOutput("t4_misaligned", 32'(fetch_misaligned), 32'd1);
    checkOutput("t4_pc_held", PC, 32'h0000_0104);
    checkOutput("t4_instret", instret, 32'd5);
    checkOutput("t4_instr_valid", 32'(instr_valid), 32'd0);
    saw_req = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid) saw_req = 1;
      tick();
    end
    checkOutput("t4_halt_no_req", 32'(saw_req), 32'd0);

    // Table of chained retires, ending in a misaligned branch
    doReset();
    exp_pc = 32'd0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].src, vecs[i].imm, vecs[i].alu, i % 3, exp_pc);
      checkOutput($sformatf("tbl%0d_pc", i), PC, vecs[i].exp_pc);
      checkOutput($sformatf("tbl%0d_mis", i), 32'(fetch_misaligned), 32'(vecs[i].exp_mis));
      checkOutput($sformatf("tbl%0d_instret", i), instret, 32'(i + 1));
      exp_pc = vecs[i].exp_pc;
    end

    // Long hold in VALID with spurious responses on the bus
    doReset();
    waitValid();
    force_spurious = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t5_instr", Instr, 32'h0320_0093);
      checkOutput("t5_pc", PC, 32'd0);
      checkOutput("t5_valid", 32'(instr_valid), 32'd1);
      checkOutput("t5_instret", instret, 32'd0);
    end
    force_spurious = 0;
    applyStimulus(2'b00, 32'd0, 32'd0, 0, 32'd0);
    checkOutput("t5_retire_instret", instret, 32'd1);
    checkOutput("t5_retire_pc", PC, 32'd4);
    waitValid();
    checkOutput("t5_next_instr", Instr, memWord(32'd4));
    checkOutput("t5_instret_once", instret, 32'd1);

    // Asynchronous reset while a response is outstanding
    lat_fixed = 6;
    applyStimulus(2'b00, 32'd0, 32'd0, 0, 32'd4);
    for (int i = 0; i < 20 && imem_req_valid; i++) tick();
    checkOutput("t6_in_wait", 32'(imem_req_valid), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("t6_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("t6_pc", PC, 32'd0);
    checkOutput("t6_instr", Instr, 32'h0000_0013);
    checkOutput("t6_instret", instret, 32'd0);
    lat_fixed = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("t6_resume_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("t6_resume_addr", imem_addr, 32'd0);
    waitValid();
    checkOutput("t6_resume_instr", Instr, 32'h0320_0093);

    // Randomized run against a transaction-level model of the PC
    doReset();
    rand_ready = 1;
    rand_lat = 1;
    spur_rand = 1;
    exp_pc = 32'd0;
    exp_cnt = 32'd0;
    for (int n = 0; n < 300; n++) begin
      src = 2'($urandom);
      k = int'($urandom_range(0, 511)) - 256;
      imm = 32'(k * 4);
      if ($urandom_range(0, 15) == 0) imm = imm + 32'd2;
      alu = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) alu = alu | 32'd2;
      case (src)
        2'b01:   nxt = exp_pc + imm;
        2'b10:   nxt = alu - (alu % 2);
        default: nxt = exp_pc + 32'd4;
      endcase
      applyStimulus(src, imm, alu, int'($urandom_range(0, 2)), exp_pc);
      exp_cnt = exp_cnt + 32'd1;
      checkOutput("rnd_instret", instret, exp_cnt);
      if (nxt % 4 != 0) begin
        checkOutput("rnd_mis", 32'(fetch_misaligned), 32'd1);
        checkOutput("rnd_pc_held", PC, exp_pc);
        saw_req = 0;
        for (int i = 0; i < 4; i++) begin
          if (imem_req_valid) saw_req = 1;
          tick();
        end
        checkOutput("rnd_halt_no_req", 32'(saw_req), 32'd0);
        doReset();
        exp_pc = 32'd0;
        exp_cnt = 32'd0;
      end else begin
        checkOutput("rnd_mis", 32'(fetch_misaligned), 32'd0);
        checkOutput("rnd_pc", PC, nxt);
        exp_pc = nxt;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of control_unit. It owns the architectural PC and issues word requests to instruction memory over a valid/ready handshake. It presents the fetched Instr to control_unit and the datapath. On each retire handshake it applies control_unit's PCSrc decision to choose the next PC (sequential, branch/JAL, or JALR).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned
XLEN, 32, width of PC, addresses and instruction data

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts the request
imem_addr  output  XLEN  byte address of the word to fetch (always equals PC)
imem_rsp_valid  input  1  read data valid
imem_rsp_data  input  XLEN  fetched instruction word
Instr  output  XLEN  registered instruction, to control_unit and decode
instr_valid  output  1  Instr holds a live instruction
instr_ready  input  1  downstream has completed execution; retire this instruction
PC  output  XLEN  address of Instr
PCPlus4  output  XLEN  PC+4, for JAL/JALR link writeback
PCSrc  input  2  from control_unit: 00 PC+4, 01 PC+ImmExt, 10 ALUResult, 11 reserved
ImmExt  input  XLEN  sign-extended branch/JAL offset
ALUResult  input  XLEN  JALR target (rs1+imm)
fetch_misaligned  output  1  sticky flag: a misaligned target was computed
instret  output  32  count of retired instructions

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - imem_req_valid=0, instr_valid=0, fetch_misaligned=0, instret=0
  - PC=imem_addr=RESET_PC, Instr=32'h0000_0013 (NOP), state=IDLE
- States: IDLE, REQ, WAIT, VALID, HALT.
- IDLE: always moves to REQ on the next clk. The first request appears in the first cycle after reset is released.
- REQ: imem_req_valid=1 and imem_addr=PC.
  - Both must stay stable until imem_req_ready=1.
  - On the accepting cycle, move to WAIT.
- WAIT: imem_req_valid=0.
  - When imem_rsp_valid=1, register imem_rsp_data into Instr, set instr_valid=1 and move to VALID.
  - The earliest response is the cycle after acceptance. A response in the same cycle as acceptance is illegal.
- imem_rsp_valid in any state other than WAIT is ignored. Instr is unchanged.
- VALID: Instr, PC and instr_valid are held while instr_ready=0.
- Retire = instr_valid & instr_ready. PCSrc, ImmExt and ALUResult are sampled only on the retire cycle. On retire:
  - next = PC+4 for PCSrc 00 or 11; PC+ImmExt for 01; {ALUResult[XLEN-1:1],1'b0} for 10. All adds are modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
  - If next[1:0]==2'b00: PC<=next, instret<=instret+1, instr_valid<=0, go to REQ.
  - If next[1:0]!=2'b00: PC is unchanged, fetch_misaligned<=1, instret<=instret+1, instr_valid<=0, go to HALT.
- HALT: no requests are issued. The block stays in HALT until reset.
- PCPlus4 = PC+4, combinational from the PC register.
- instret wraps 32'hFFFF_FFFF -> 0.
- Throughput: at most one instruction per 3 cycles (REQ, WAIT, VALID) with zero-wait memory.
- Reset mid-transaction: the state returns to IDLE at once, even if a request is outstanding. The memory is on the same rst_n, so no stale response can arrive.

Decomposition:
- Shared package riscv_pkg holds:
  - enum pcsrc_e (PC_PLUS4=2'b00, PC_TARGET=2'b01, PC_ALU=2'b10)
  - enum fetch_state_e
  - constants NOP_INSTR=32'h0000_0013 and XLEN
- One combinational sub-module, next_pc_logic: inputs PC, PCSrc, ImmExt, ALUResult; outputs next and misaligned. Unit-testable on its own.
- The FSM, PC, Instr and instret registers stay in fetch_unit.

Test Plan:
1. Reset, then zero-wait memory returning 32'h03200093 -> imem_addr=0x0 at the 1st post-reset cycle; instr_valid=1 two cycles after acceptance with Instr=32'h03200093; PC=0; PCPlus4=4.
2. Retire with PCSrc=00 at PC=0x0, memory stalls imem_req_ready low 3 cycles -> imem_addr=0x4 held stable for 4 cycles; instret=1.
3. BEQ at PC=0x8, PCSrc=01, ImmExt=32'hFFFF_FFF8 -> next request imem_addr=0x0; PC=0x0.
4. JALR, PCSrc=10, ALUResult=0x0000_0105 -> PC=0x104 (bit 0 cleared); then ALUResult=0x0000_0106 -> fetch_misaligned=1, no further imem_req_valid, instret still incremented.
5. instr_ready held low 5 cycles in VALID, with a spurious imem_rsp_valid carrying 0xDEADBEEF -> Instr/PC unchanged, no retire; a later retire advances exactly once.
6. Assert rst_n low while in WAIT -> same cycle: imem_req_valid=0, instr_valid=0, PC=RESET_PC, Instr=NOP, instret=0; fetch resumes from RESET_PC after release.
